// File: rtl/fifo8x9_pkg.sv
// Shared constants and types for the 8x9 FIFO control stage.
// Optional almost-flag thresholds apply only with FIFO_ALMOST_FLAGS_EN.
package fifo8x9_pkg;

  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;
  localparam int DATA_W = 9;
  localparam int AF_LVL = 6;
  localparam int AE_LVL = 2;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/fifo8x9_occ_cnt.sv
// Up/down occupancy counter with registered full/empty flags.
// Almost flags exist only when FIFO_ALMOST_FLAGS_EN is defined.
module fifo8x9_occ_cnt
  import fifo8x9_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
`ifdef FIFO_ALMOST_FLAGS_EN
  output logic             almost_full,
  output logic             almost_empty,
`endif
  output logic             empty
);

  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = count;
    if (clr)
      cnt_d = '0;
    else if (inc && !dec)
      cnt_d = count + 1'b1;
    else if (dec && !inc)
      cnt_d = count - 1'b1;
  end

  // Flags come from the next count so they stay in step with count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      count <= cnt_d;
      full  <= (cnt_d == CNT_W'(DEPTH));
      empty <= (cnt_d == '0);
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (cnt_d >= CNT_W'(AF_LVL));
      almost_empty <= (cnt_d <= CNT_W'(AE_LVL));
    end
  end
`endif

endmodule

// File: rtl/fifo8x9_ctrl.sv
// Control stage for the 8x9 FIFO datapath: strobes, occupancy, sticky errors.
// Define FIFO_ALMOST_FLAGS_EN to add almost_full/almost_empty outputs.
module fifo8x9_ctrl
  import fifo8x9_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             rd_oe,
  output logic             WrInc,
  output logic             wren,
  output logic             RdInc,
  output logic             rden,
  output logic             WrPtrClr,
  output logic             RdPtrClr,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             rd_valid,
  output logic             ovf,
`ifdef FIFO_ALMOST_FLAGS_EN
  output logic             almost_full,
  output logic             almost_empty,
`endif
  output logic             udf
);

  state_t state, state_d;
  logic   push_acc, pop_acc;
  logic   push_rej, pop_rej;
  logic   clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= INIT;
    else
      state <= state_d;
  end

  always_comb begin
    state_d  = state;
    clr      = 1'b0;
    push_acc = 1'b0;
    pop_acc  = 1'b0;
    push_rej = 1'b0;
    pop_rej  = 1'b0;
    unique case (state)
      INIT: begin
        clr     = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        // A pop on a full FIFO frees the slot this same push lands in.
        pop_acc  = pop & ~empty;
        push_acc = push & (~full | pop_acc);
        pop_rej  = pop & ~pop_acc;
        push_rej = push & ~push_acc;
        if (flush)
          state_d = FLUSH;
      end
      FLUSH: begin
        clr     = 1'b1;
        state_d = RUN;
      end
      default: begin
        clr     = 1'b1;
        state_d = INIT;
      end
    endcase
  end

  assign WrPtrClr = clr;
  assign RdPtrClr = clr;
  assign WrInc    = push_acc;
  assign wren     = push_acc;
  assign RdInc    = pop_acc;
  assign rden     = rd_oe & (state != INIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf      <= 1'b0;
      udf      <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop_acc & rd_oe;
      if (state == FLUSH) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        ovf <= ovf | push_rej;
        udf <= udf | pop_rej;
      end
    end
  end

  fifo8x9_occ_cnt u_occ (
    .clk          (clk),
    .rst          (rst),
    .clr          (state == FLUSH),
    .inc          (push_acc),
    .dec          (pop_acc),
    .count        (count),
    .full         (full),
`ifdef FIFO_ALMOST_FLAGS_EN
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`endif
    .empty        (empty)
  );

endmodule
